multich_scan_sequencer: RTL
===========================

// Module: multich_scan_sequencer
// PURPOSE
//  Parametrised channel-scan sequencer for the multichannel pulse counter.
//  Steps a binary channel select through the enabled channels of a
//  per-frame mask, spending SLOTS_PER_CH ticks on each channel.
//  Generates the shift/load strobe, the end-of-frame pulse and the RTC
//  output reset. Sits between the tick sources (counter overflow, RTC)
//  and the channel mux / shift-register readout path.
// PARAMETERS
//  NUM_CH        6   number of channels scanned (2..2**SEL_W)
//  SEL_W         3   width of ch_sel; must be >= clog2(NUM_CH)
//  SLOTS_PER_CH  12  ticks spent per channel (>=2)
//  SLOT_W        4   width of slot; must be >= clog2(SLOTS_PER_CH)
//  FRAME_W       8   width of the completed-frame counter
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  reset      in   1        synchronous, active-high reset
//  ovf        in   1        pulse-counter overflow tick
//  ovf_rtc    in   1        RTC tick
//  enable     in   1        run request; sampled each cycle
//  ch_mask    in   NUM_CH   channel enable mask; bit i = channel i
//  ch_sel     out  SEL_W    binary index of the selected channel
//  ch_valid   out  1        high while in SCAN
//  slot       out  SLOT_W   tick slot within the current channel
//  sl         out  1        shift/load strobe, 1-cycle pulse
//  frame_done out  1        end-of-frame pulse, 1 cycle
//  out_rst    out  1        output reset, 1 cycle, only on RTC-ended frame
//  frame_cnt  out  FRAME_W  completed frames, wraps 2**FRAME_W-1 -> 0
// BEHAVIOUR
//  - tick = ovf | ovf_rtc; simultaneous ovf and ovf_rtc count as ONE tick.
//  - Reset: state=IDLE. ch_sel, slot, frame_cnt = 0. ch_valid, sl,
//    frame_done, out_rst = 0. Applies on the next edge from any state,
//    mid-frame included. Resets the mask register to 0.
//  - All outputs are registered and update on the edge that samples
//    the tick: 0 cycles extra latency.
//  - FSM states: IDLE, SCAN, WRAP.
//  - IDLE: when enable=1 and ch_mask!=0, latch ch_mask into mask_q,
//    set ch_sel = lowest set bit, slot=0, and go to SCAN. Otherwise
//    stay in IDLE. Ticks are ignored in IDLE.
//  - SCAN, tick with slot < SLOTS_PER_CH-1: slot <= slot+1.
//  - SCAN, tick with slot == SLOTS_PER_CH-1: slot <= 0. If mask_q has a
//    set bit above ch_sel, ch_sel <= next such bit (disabled channels
//    skipped) and stay in SCAN. Otherwise go to WRAP, and latch
//    rtc_end = ovf_rtc.
//  - sl = 1 for exactly the cycle after a SCAN tick moves slot 0->1,
//    so one pulse per visited channel.
//  - WRAP lasts one cycle, during which:
//      - frame_done=1 and frame_cnt is incremented;
//      - out_rst = rtc_end;
//      - ch_valid=0, and ticks arriving in this cycle are dropped.
//    Exit: if enable=1 and ch_mask!=0, relatch mask_q, select its lowest
//    channel and go to SCAN. Else go to IDLE with ch_sel=0.
//  - ch_mask changes during a frame are ignored until the next latch.
//  - enable=0 during SCAN does not abort: the frame completes, then
//    WRAP -> IDLE.
//  - Mask with a single bit: that channel is scanned, then WRAP, every
//    frame.
//  - ch_sel bits above NUM_CH-1 are never produced.
// TESTING
//  1 Defaults, mask=6'b111111, enable=1, tick every cycle -> ch_sel goes
//    0..5, 12 cycles each. frame_done on the cycle after the 72nd tick;
//    frame_cnt=1; next frame restarts at ch_sel=0.
//  2 mask=6'b100101 -> ch_sel sequence 0,2,5 and frame_done after 36
//    ticks. sl pulses exactly 3 times per frame.
//  3 Last tick via ovf_rtc -> out_rst=1 together with frame_done. Via ovf
//    only -> out_rst=0. ovf=ovf_rtc=1 in the same cycle -> slot advances
//    by 1 only.
//  4 Drop enable while ch_sel=2, and change mask mid-frame -> scan uses
//    the old mask to the end, then WRAP and IDLE (ch_valid=0,
//    ch_sel=0). Further ticks are ignored.
//  5 Assert reset at ch_sel=3, slot=7 -> after the next edge all outputs
//    are 0 and state is IDLE. enable=1 with mask=0 -> remains IDLE.
//  6 FRAME_W=2, run 5 frames -> frame_cnt goes 1,2,3,0,1.

Source files
------------

// File: rtl/multich_scan_sequencer_if.sv
// Tick/control inputs and scan outputs of the channel-scan sequencer.
// master drives ticks, enable and mask; slave is the sequencer itself.
interface multich_scan_sequencer_if #(
  parameter int NUM_CH  = 6,
  parameter int SEL_W   = 3,
  parameter int SLOT_W  = 4,
  parameter int FRAME_W = 8
);
  logic               ovf;
  logic               ovf_rtc;
  logic               enable;
  logic [NUM_CH-1:0]  ch_mask;
  logic [SEL_W-1:0]   ch_sel;
  logic               ch_valid;
  logic [SLOT_W-1:0]  slot;
  logic               sl;
  logic               frame_done;
  logic               out_rst;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output ovf, ovf_rtc, enable, ch_mask,
    input  ch_sel, ch_valid, slot, sl, frame_done, out_rst, frame_cnt
  );

  modport slave (
    input  ovf, ovf_rtc, enable, ch_mask,
    output ch_sel, ch_valid, slot, sl, frame_done, out_rst, frame_cnt
  );
endinterface

// File: rtl/multich_scan_sequencer.sv
// Channel-scan sequencer: walks the enabled channels of a latched mask,
// SLOTS_PER_CH ticks each, then spends one WRAP cycle closing the frame.
module multich_scan_sequencer #(
  parameter int NUM_CH       = 6,
  parameter int SEL_W        = 3,
  parameter int SLOTS_PER_CH = 12,
  parameter int SLOT_W       = 4,
  parameter int FRAME_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  multich_scan_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, WRAP} state_e;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_CH - 1);

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               sl_q, sl_d;
  logic               rtc_end_q, rtc_end_d;

  logic               tick, start, has_next;
  logic [SEL_W-1:0]   first_sel, next_sel;

  // Simultaneous ovf/ovf_rtc collapse into a single tick.
  assign tick  = bus.ovf | bus.ovf_rtc;
  assign start = bus.enable && (bus.ch_mask != '0);

  // Descending scan so the lowest qualifying bit wins.
  always_comb begin
    first_sel = '0;
    next_sel  = '0;
    has_next  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) first_sel = SEL_W'(i);
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_sel = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    sel_d     = sel_q;
    slot_d    = slot_q;
    frame_d   = frame_q;
    sl_d      = 1'b0;
    rtc_end_d = rtc_end_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = bus.ch_mask;
          sel_d   = first_sel;
          slot_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (tick) begin
          sl_d = (slot_q == '0);
          if (slot_q != LAST_SLOT) begin
            slot_d = slot_q + SLOT_W'(1);
          end else begin
            slot_d = '0;
            if (has_next) begin
              sel_d = next_sel;
            end else begin
              state_d   = WRAP;
              rtc_end_d = bus.ovf_rtc;
              frame_d   = frame_q + FRAME_W'(1);
            end
          end
        end
      end
      WRAP: begin
        // Ticks in this cycle are intentionally not looked at.
        if (start) begin
          mask_d  = bus.ch_mask;
          sel_d   = first_sel;
          slot_d  = '0;
          state_d = SCAN;
        end else begin
          sel_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      sel_q     <= '0;
      slot_q    <= '0;
      frame_q   <= '0;
      sl_q      <= 1'b0;
      rtc_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      sel_q     <= sel_d;
      slot_q    <= slot_d;
      frame_q   <= frame_d;
      sl_q      <= sl_d;
      rtc_end_q <= rtc_end_d;
    end
  end

  assign bus.ch_sel     = sel_q;
  assign bus.slot       = slot_q;
  assign bus.sl         = sl_q;
  assign bus.frame_cnt  = frame_q;
  assign bus.ch_valid   = (state_q == SCAN);
  assign bus.frame_done = (state_q == WRAP);
  assign bus.out_rst    = (state_q == WRAP) && rtc_end_q;
endmodule
